// File: rtl/bit_field_packer_pkg.sv
// Shared types and helpers for the bit-field packer: FSM state encoding,
// default widths and the field-length clamp.
package bit_field_packer_pkg;

    localparam int DEF_WORD_W  = 32;
    localparam int DEF_FIELD_W = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } packer_state_e;

    // Lengths beyond the field width are treated as a full-width field.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned field_w);
        return (len > field_w) ? field_w : len;
    endfunction

endpackage

// File: rtl/bit_field_packer_field_insert.sv
// Combinational variable-offset insertion of one masked field into the
// accumulator; yields the candidate word, the spill-over bits and the new fill.
module bit_field_packer_field_insert #(
    parameter int WORD_W  = 32,
    parameter int FIELD_W = 8,
    parameter int LEN_W   = $clog2(FIELD_W + 1),
    parameter int PTR_W   = $clog2(WORD_W)
) (
    input  logic [WORD_W-1:0]  acc,
    input  logic [PTR_W-1:0]   fill,
    input  logic [FIELD_W-1:0] field,
    input  logic [LEN_W-1:0]   len,
    output logic [WORD_W-1:0]  word,
    output logic [FIELD_W-1:0] carry,
    output logic [PTR_W:0]     total,
    output logic [PTR_W-1:0]   next_fill,
    output logic               overflow
);

    logic [WORD_W+FIELD_W-1:0] wide_acc;
    logic [WORD_W+FIELD_W-1:0] wide_field;
    logic [WORD_W+FIELD_W-1:0] merged;

    assign wide_acc   = {{FIELD_W{1'b0}}, acc};
    assign wide_field = {{WORD_W{1'b0}}, field};
    assign merged     = wide_acc | (wide_field << fill);

    assign word  = merged[WORD_W-1:0];
    assign carry = merged[WORD_W +: FIELD_W];

    // WORD_W is a power of two, so the top bit of the sum is the word-complete flag.
    assign total     = {1'b0, fill} + (PTR_W + 1)'(len);
    assign overflow  = total[PTR_W];
    assign next_fill = total[PTR_W-1:0];

endmodule

// File: rtl/bit_field_packer.sv
// Packs variable-width fields LSB-first into fixed-width words with
// valid/ready on both sides and an end-of-packet flush of the partial word.
module bit_field_packer
    import bit_field_packer_pkg::*;
#(
    parameter  int WORD_W  = DEF_WORD_W,
    parameter  int FIELD_W = DEF_FIELD_W,
    localparam int LEN_W   = $clog2(FIELD_W + 1),
    localparam int BITS_W  = $clog2(WORD_W + 1),
    localparam int PTR_W   = $clog2(WORD_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIELD_W-1:0] in_data,
    input  logic [LEN_W-1:0]   in_len,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic [BITS_W-1:0]  out_bits,
    output logic               out_last
);

    packer_state_e      state, state_n;
    logic [WORD_W-1:0]  acc, acc_n;
    logic [PTR_W-1:0]   fill, fill_n;
    logic               valid_n, last_n;
    logic [WORD_W-1:0]  data_n;
    logic [BITS_W-1:0]  bits_n;

    logic [LEN_W-1:0]   len_eff;
    logic [FIELD_W-1:0] field;
    logic [WORD_W-1:0]  ins_word;
    logic [FIELD_W-1:0] ins_carry;
    logic [PTR_W:0]     ins_total;
    logic [PTR_W-1:0]   ins_next_fill;
    logic               ins_overflow;
    logic               out_free;
    logic               accept;

    assign len_eff = LEN_W'(eff_len(32'(in_len), FIELD_W));
    assign field   = in_data & ~({FIELD_W{1'b1}} << len_eff);

    bit_field_packer_field_insert #(
        .WORD_W (WORD_W),
        .FIELD_W(FIELD_W),
        .LEN_W  (LEN_W),
        .PTR_W  (PTR_W)
    ) u_insert (
        .acc      (acc),
        .fill     (fill),
        .field    (field),
        .len      (len_eff),
        .word     (ins_word),
        .carry    (ins_carry),
        .total    (ins_total),
        .next_fill(ins_next_fill),
        .overflow (ins_overflow)
    );

    // Input stalls whenever the output slot is occupied and not draining,
    // even if this beat would not complete a word.
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == RUN) && out_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        fill_n  = fill;
        valid_n = out_valid && !out_ready;
        data_n  = out_data;
        bits_n  = out_bits;
        last_n  = out_last;

        unique case (state)
            RUN: begin
                if (accept) begin
                    if (!ins_overflow) begin
                        acc_n  = ins_word;
                        fill_n = ins_next_fill;
                        if (in_last && (ins_total != '0)) begin
                            valid_n = 1'b1;
                            data_n  = ins_word;
                            bits_n  = BITS_W'(ins_total);
                            last_n  = 1'b1;
                            acc_n   = '0;
                            fill_n  = '0;
                        end
                    end else begin
                        valid_n = 1'b1;
                        data_n  = ins_word;
                        bits_n  = BITS_W'(WORD_W);
                        last_n  = in_last && (ins_next_fill == '0);
                        acc_n   = {{(WORD_W - FIELD_W){1'b0}}, ins_carry};
                        fill_n  = ins_next_fill;
                        if (in_last && (ins_next_fill != '0)) begin
                            state_n = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    valid_n = 1'b1;
                    data_n  = acc;
                    bits_n  = BITS_W'({1'b0, fill});
                    last_n  = 1'b1;
                    acc_n   = '0;
                    fill_n  = '0;
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            acc       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bits  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            fill      <= fill_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            out_bits  <= bits_n;
            out_last  <= last_n;
        end
    end

endmodule
